// File: rtl/sseg_defs_pkg.sv
`default_nettype none
// ===========================================================================
// sseg_defs_pkg : segment patterns, FSM encodings and double-dabble helper
// Rev 1.0
// ===========================================================================
package sseg_defs_pkg;

  localparam int SSEG_DIGITS = 4;
  localparam int BCD_W       = 4 * SSEG_DIGITS;
  localparam int MAX_DISPLAY = 9999;

  // Pattern bit order is {g,f,e,d,c,b,a}; a lit segment is 1.
  localparam int SEG_A_BIT = 0;
  localparam int SEG_G_BIT = 6;

  localparam logic [6:0] SEG_BLANK = 7'h00;
  localparam logic [6:0] SEG_DASH  = 7'b1000000;
  localparam logic [6:0] SEG_0     = 7'b0111111;
  localparam logic [6:0] SEG_1     = 7'b0000110;
  localparam logic [6:0] SEG_2     = 7'b1011011;
  localparam logic [6:0] SEG_3     = 7'b1001111;
  localparam logic [6:0] SEG_4     = 7'b1100110;
  localparam logic [6:0] SEG_5     = 7'b1101101;
  localparam logic [6:0] SEG_6     = 7'b1111101;
  localparam logic [6:0] SEG_7     = 7'b0000111;
  localparam logic [6:0] SEG_8     = 7'b1111111;
  localparam logic [6:0] SEG_9     = 7'b1101111;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_CONVERT = 2'd1;
  localparam logic [1:0] ST_UPDATE  = 2'd2;

  // Add-3 correction applied to every BCD nibble before each shift.
  function automatic logic [BCD_W-1:0] dd_adjust(input logic [BCD_W-1:0] bcd);
    logic [BCD_W-1:0] r;
    for (int n = 0; n < SSEG_DIGITS; n++) begin
      r[4*n +: 4] = (bcd[4*n +: 4] >= 4'd5) ? bcd[4*n +: 4] + 4'd3 : bcd[4*n +: 4];
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sseg_digit_decoder.sv
`default_nettype none
// ===========================================================================
// sseg_digit_decoder : 4-bit BCD to 7-segment pattern, codes 10..15 blank
// Rev 1.0
// ===========================================================================
module sseg_digit_decoder
  import sseg_defs_pkg::*;
(
  input  logic [3:0] i_bcd,
  output logic [6:0] o_seg
);

  always_comb begin
    o_seg = SEG_BLANK;
    case (i_bcd)
      4'd0:    o_seg = SEG_0;
      4'd1:    o_seg = SEG_1;
      4'd2:    o_seg = SEG_2;
      4'd3:    o_seg = SEG_3;
      4'd4:    o_seg = SEG_4;
      4'd5:    o_seg = SEG_5;
      4'd6:    o_seg = SEG_6;
      4'd7:    o_seg = SEG_7;
      4'd8:    o_seg = SEG_8;
      4'd9:    o_seg = SEG_9;
      default: o_seg = SEG_BLANK;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/bin_to_sseg_digits.sv
`default_nettype none
// ===========================================================================
// bin_to_sseg_digits : sequential double-dabble binary to four 7-seg digits
// Rev 1.0
// ===========================================================================
module bin_to_sseg_digits
  import sseg_defs_pkg::*;
#(
  parameter int WIDTH = 14
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_value,
  input  logic             i_blank_lz,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_overflow,
  output logic [6:0]       o_sseg_1,
  output logic [6:0]       o_sseg_2,
  output logic [6:0]       o_sseg_3,
  output logic [6:0]       o_sseg_4
);

  localparam int               CNT_W    = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WIDTH);

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] bin_q, bin_d;
  logic [BCD_W-1:0] bcd_q, bcd_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             blank_q, blank_d;
  logic             ovf_flag_q, ovf_flag_d;
  logic             ovf_q, ovf_d;
  logic [6:0]       seg_q [SSEG_DIGITS];
  logic [6:0]       seg_d [SSEG_DIGITS];

  logic [BCD_W-1:0]       w_bcd_step;
  logic [WIDTH-1:0]       w_bin_step;
  logic [6:0]             w_dec  [SSEG_DIGITS];
  logic [6:0]             w_disp [SSEG_DIGITS];
  logic [SSEG_DIGITS-1:0] w_nz;

  // One double-dabble iteration; bits pushed out of the BCD register are dropped.
  always_comb begin
    {w_bcd_step, w_bin_step} = {dd_adjust(bcd_q), bin_q} << 1;
  end

  // Decoding the post-step BCD lets the final iteration and the output latch share one edge.
  for (genvar gi = 0; gi < SSEG_DIGITS; gi++) begin : g_dec
    sseg_digit_decoder u_dec (
      .i_bcd (w_bcd_step[4*gi +: 4]),
      .o_seg (w_dec[gi])
    );
    assign w_nz[gi] = |w_bcd_step[4*gi +: 4];
  end

  always_comb begin
    for (int i = 0; i < SSEG_DIGITS; i++) begin
      w_disp[i] = w_dec[i];
      if (ovf_flag_q) begin
        w_disp[i] = SEG_DASH;
      end else if (blank_q && (i > 0) && ((w_nz >> i) == '0)) begin
        w_disp[i] = SEG_BLANK;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q    <= ST_IDLE;
      bin_q      <= '0;
      bcd_q      <= '0;
      cnt_q      <= '0;
      blank_q    <= 1'b0;
      ovf_flag_q <= 1'b0;
      ovf_q      <= 1'b0;
      for (int i = 0; i < SSEG_DIGITS; i++) seg_q[i] <= SEG_BLANK;
    end else begin
      state_q    <= state_d;
      bin_q      <= bin_d;
      bcd_q      <= bcd_d;
      cnt_q      <= cnt_d;
      blank_q    <= blank_d;
      ovf_flag_q <= ovf_flag_d;
      ovf_q      <= ovf_d;
      for (int i = 0; i < SSEG_DIGITS; i++) seg_q[i] <= seg_d[i];
    end
  end

  always_comb begin
    state_d    = state_q;
    bin_d      = bin_q;
    bcd_d      = bcd_q;
    cnt_d      = cnt_q;
    blank_d    = blank_q;
    ovf_flag_d = ovf_flag_q;
    ovf_d      = ovf_q;
    for (int i = 0; i < SSEG_DIGITS; i++) seg_d[i] = seg_q[i];
    case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          bin_d      = i_value;
          bcd_d      = '0;
          cnt_d      = CNT_INIT;
          blank_d    = i_blank_lz;
          ovf_flag_d = (32'(i_value) > 32'(MAX_DISPLAY));
          state_d    = ST_CONVERT;
        end
      end
      ST_CONVERT: begin
        bin_d = w_bin_step;
        bcd_d = w_bcd_step;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          for (int i = 0; i < SSEG_DIGITS; i++) seg_d[i] = w_disp[i];
          ovf_d   = ovf_flag_q;
          state_d = ST_UPDATE;
        end
      end
      ST_UPDATE: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    o_busy     = (state_q != ST_IDLE);
    o_done     = (state_q == ST_UPDATE);
    o_overflow = ovf_q;
    o_sseg_1   = seg_q[0];
    o_sseg_2   = seg_q[1];
    o_sseg_3   = seg_q[2];
    o_sseg_4   = seg_q[3];
  end

endmodule
`default_nettype wire

// File: tb/tb_bin_to_sseg_digits.sv
`default_nettype none
// ===========================================================================
// tb_bin_to_sseg_digits : randomized bench with a decimal-arithmetic reference
// Rev 1.0
// ===========================================================================
module tb_bin_to_sseg_digits;

  localparam int WIDTH = 14;

  logic             i_clk = 1'b0;
  logic             i_reset = 1'b1;
  logic             i_start = 1'b0;
  logic [WIDTH-1:0] i_value = '0;
  logic             i_blank_lz = 1'b0;
  logic             o_busy, o_done, o_overflow;
  logic [6:0]       o_sseg_1, o_sseg_2, o_sseg_3, o_sseg_4;

  int n_vec = 0;
  int n_err = 0;

  logic [6:0] seg_tab [10] = '{7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111, 7'b1100110,
                               7'b1101101, 7'b1111101, 7'b0000111, 7'b1111111, 7'b1101111};

  bin_to_sseg_digits #(.WIDTH(WIDTH)) dut (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_start    (i_start),
    .i_value    (i_value),
    .i_blank_lz (i_blank_lz),
    .o_busy     (o_busy),
    .o_done     (o_done),
    .o_overflow (o_overflow),
    .o_sseg_1   (o_sseg_1),
    .o_sseg_2   (o_sseg_2),
    .o_sseg_3   (o_sseg_3),
    .o_sseg_4   (o_sseg_4)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Display {sseg_4,sseg_3,sseg_2,sseg_1} derived from decimal digits of v.
  function automatic logic [27:0] model_segs(input int v, input bit bl);
    int d [4];
    int msd;
    logic [27:0] r;
    if (v > 9999) return {4{7'b1000000}};
    msd = 0;
    for (int i = 0; i < 4; i++) begin
      d[i] = (v / (10 ** i)) % 10;
      if (d[i] != 0) msd = i;
    end
    for (int i = 0; i < 4; i++) r[7*i +: 7] = (bl && i > msd) ? 7'h00 : seg_tab[d[i]];
    return r;
  endfunction

  // Reference: a conversion occupies WIDTH+1 cycles after acceptance, done in the last.
  int          m_age = 0;
  int          m_val = 0;
  bit          m_bl  = 1'b0;
  logic [27:0] m_seg = '0;
  bit          m_ovf = 1'b0;

  always @(posedge i_clk) begin
    if (i_reset) begin
      m_age = 0;
      m_seg = '0;
      m_ovf = 1'b0;
    end else if (m_age == 0) begin
      if (i_start) begin
        m_age = 1;
        m_val = int'(i_value);
        m_bl  = i_blank_lz;
      end
    end else if (m_age < WIDTH + 1) begin
      m_age++;
      if (m_age == WIDTH + 1) begin
        m_seg = model_segs(m_val, m_bl);
        m_ovf = (m_val > 9999);
      end
    end else begin
      m_age = 0;
    end
    #1;
    check("busy", 32'(o_busy), 32'(m_age != 0));
    check("done", 32'(o_done), 32'(m_age == WIDTH + 1));
    check("overflow", 32'(o_overflow), 32'(m_ovf));
    check("segs", 32'({o_sseg_4, o_sseg_3, o_sseg_2, o_sseg_1}), 32'(m_seg));
  end

  task automatic launch(input int v, input bit bl);
    i_start    = 1'b1;
    i_value    = WIDTH'(v);
    i_blank_lz = bl;
    @(negedge i_clk);
    i_start = 1'b0;
  endtask

  task automatic wait_done();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge i_clk);
      if (o_done) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic lit(input string name, input logic [27:0] exp, input bit ovf);
    check(name, 32'({o_sseg_4, o_sseg_3, o_sseg_2, o_sseg_1}), 32'(exp));
    check({name, "_ovf"}, 32'(o_overflow), 32'(ovf));
  endtask

  function automatic int rand_value();
    case ($urandom_range(0, 3))
      0:       return int'($urandom_range(10000, 16383));
      1:       return int'($urandom_range(0, 99));
      default: return int'($urandom_range(0, 9999));
    endcase
  endfunction

  initial begin
    repeat (3) @(negedge i_clk);
    lit("reset_segs", 28'h0, 1'b0);
    check("reset_busy", 32'(o_busy), 32'd0);
    i_reset = 1'b0;
    @(negedge i_clk);

    launch(1234, 1'b0); wait_done();
    lit("v1234", {7'b0000110, 7'b1011011, 7'b1001111, 7'b1100110}, 1'b0);
    @(negedge i_clk);

    launch(0, 1'b1); wait_done();
    lit("v0_blank", {7'h00, 7'h00, 7'h00, 7'b0111111}, 1'b0);
    @(negedge i_clk);
    launch(42, 1'b1); wait_done();
    lit("v42_blank", {7'h00, 7'h00, 7'b1100110, 7'b1011011}, 1'b0);
    @(negedge i_clk);
    launch(1005, 1'b1); wait_done();
    lit("v1005_blank", {7'b0000110, 7'b0111111, 7'b0111111, 7'b1101101}, 1'b0);
    @(negedge i_clk);

    launch(9999, 1'b0); wait_done();
    lit("v9999", {4{7'b1101111}}, 1'b0);
    @(negedge i_clk);
    launch(10000, 1'b1); wait_done();
    lit("v10000", {4{7'b1000000}}, 1'b1);
    @(negedge i_clk);

    // Start during conversion is ignored; start held across done is taken a cycle later.
    launch(1234, 1'b0);
    repeat (2) @(negedge i_clk);
    launch(5678, 1'b0);
    wait_done();
    lit("ignored_5678", {7'b0000110, 7'b1011011, 7'b1001111, 7'b1100110}, 1'b0);
    i_start = 1'b1;
    i_value = WIDTH'(4321);
    repeat (2) @(negedge i_clk);
    i_start = 1'b0;
    wait_done();
    lit("v4321", {7'b1100110, 7'b1001111, 7'b1011011, 7'b0000110}, 1'b0);
    @(negedge i_clk);

    // Reset in the middle of a conversion.
    launch(1234, 1'b0);
    repeat (5) @(negedge i_clk);
    i_reset = 1'b1;
    @(negedge i_clk);
    i_reset = 1'b0;
    lit("abort_segs", 28'h0, 1'b0);
    check("abort_busy", 32'(o_busy), 32'd0);
    launch(8, 1'b0); wait_done();
    lit("v8", {7'b0111111, 7'b0111111, 7'b0111111, 7'b1111111}, 1'b0);
    @(negedge i_clk);

    // Start held high: back-to-back conversions with changing inputs.
    i_start = 1'b1;
    for (int i = 0; i < 4 * (WIDTH + 2); i++) begin
      i_value    = WIDTH'(rand_value());
      i_blank_lz = 1'($urandom_range(0, 1));
      @(negedge i_clk);
    end
    i_start = 1'b0;
    for (int i = 0; i < 2 * WIDTH + 4 && o_busy; i++) @(negedge i_clk);
    @(negedge i_clk);

    // Randomized conversions with occasional stray start pulses.
    for (int n = 0; n < 50; n++) begin
      repeat ($urandom_range(0, 3)) @(negedge i_clk);
      launch(rand_value(), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 1) == 1) begin
        repeat ($urandom_range(1, 10)) @(negedge i_clk);
        launch(rand_value(), 1'($urandom_range(0, 1)));
      end
      wait_done();
      @(negedge i_clk);
    end

    repeat (3) @(negedge i_clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
